// File: rtl/laser_aom_dac_drv.sv
// Serialises AOM voltage updates into 16-bit DAC7311-style SPI write frames.
// Updates that arrive while a frame is in flight coalesce into one pending slot.
module laser_aom_dac_drv #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SYNC_GAP = 4,
  parameter real         TCQ      = 0.1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        aom_en_i,
  input  logic [11:0] aom_voltage_i,
  output logic        dac_sync_n_o,
  output logic        dac_sclk_o,
  output logic        dac_din_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [11:0] dac_voltage_o,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

  if (CLK_DIV < 1 || SYNC_GAP < 1 || TCQ < 0.0) begin : g_illegal_params
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [14:0]      shift_q, shift_d;
  logic [11:0]      code_q, code_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic [11:0]      pend_q, pend_d;
  logic [15:0]      drop_q, drop_d;
  logic             sync_n_q, sync_n_d;
  logic             sclk_q, sclk_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [11:0]      dac_voltage_q, dac_voltage_d;

  logic             start;
  logic             drop_inc;
  logic [11:0]      start_code;
  logic [15:0]      frame;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    code_d        = code_q;
    div_cnt_d     = div_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_d        = pend_q;
    drop_d        = drop_q;
    sync_n_d      = sync_n_q;
    sclk_d        = sclk_q;
    din_d         = din_q;
    done_d        = 1'b0;
    dac_voltage_d = dac_voltage_q;
    start         = 1'b0;
    drop_inc      = 1'b0;
    start_code    = aom_voltage_i;

    case (state_q)
      IDLE: begin
        if (aom_en_i) start = 1'b1;
      end
      SHIFT: begin
        if (aom_en_i) begin
          drop_inc     = pend_valid_q;
          pend_valid_d = 1'b1;
          pend_d       = aom_voltage_i;
        end
        if (div_cnt_q != DIV_LAST) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == 4'd15) begin
            sync_n_d      = 1'b1;
            sclk_d        = 1'b1;
            din_d         = 1'b0;
            done_d        = 1'b1;
            dac_voltage_d = code_q;
            gap_cnt_d     = '0;
            state_d       = GAP;
          end else begin
            sclk_d    = 1'b1;
            din_d     = shift_q[14];
            shift_d   = {shift_q[13:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          if (aom_en_i) begin
            drop_inc     = pend_valid_q;
            pend_valid_d = 1'b1;
            pend_d       = aom_voltage_i;
          end
        end else if (aom_en_i) begin
          // a fresh strobe on the exit cycle supersedes whatever was pending
          start        = 1'b1;
          drop_inc     = pend_valid_q;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          start        = 1'b1;
          start_code   = pend_q;
          pend_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    frame = {2'b00, start_code, 2'b00};
    if (start) begin
      state_d   = SHIFT;
      code_d    = start_code;
      din_d     = frame[15];
      shift_d   = frame[14:0];
      sync_n_d  = 1'b0;
      sclk_d    = 1'b1;
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end

    if (drop_inc && (drop_q != '1)) drop_d = drop_q + 16'd1;
    busy_d = (state_d != IDLE) | pend_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      code_q        <= '0;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      pend_valid_q  <= 1'b0;
      pend_q        <= '0;
      drop_q        <= '0;
      sync_n_q      <= 1'b1;
      sclk_q        <= 1'b1;
      din_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      dac_voltage_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      code_q        <= code_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_q        <= pend_d;
      drop_q        <= drop_d;
      sync_n_q      <= sync_n_d;
      sclk_q        <= sclk_d;
      din_q         <= din_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      dac_voltage_q <= dac_voltage_d;
    end
  end

  assign dac_sync_n_o  = sync_n_q;
  assign dac_sclk_o    = sclk_q;
  assign dac_din_o     = din_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign dac_voltage_o = dac_voltage_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_laser_aom_dac_drv.sv
// Bench for laser_aom_dac_drv: two instances (CLK_DIV/SYNC_GAP = 4/4 and 1/1) share one
// stimulus stream and are checked every cycle against a frame-timeline model.
module tb_laser_aom_dac_drv;

  localparam int D0 = 4;
  localparam int G0 = 4;
  localparam int D1 = 1;
  localparam int G1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic [11:0] v = '0;

  logic [1:0] sync_n, sclk, din, busy, done;
  logic [1:0][11:0] dacv;
  logic [1:0][15:0] drop;

  laser_aom_dac_drv #(.CLK_DIV(D0), .SYNC_GAP(G0), .TCQ(0.1)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .aom_en_i(en), .aom_voltage_i(v),
    .dac_sync_n_o(sync_n[0]), .dac_sclk_o(sclk[0]), .dac_din_o(din[0]),
    .busy_o(busy[0]), .frame_done_o(done[0]), .dac_voltage_o(dacv[0]),
    .drop_cnt_o(drop[0])
  );

  laser_aom_dac_drv #(.CLK_DIV(D1), .SYNC_GAP(G1), .TCQ(0.1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .aom_en_i(en), .aom_voltage_i(v),
    .dac_sync_n_o(sync_n[1]), .dac_sclk_o(sclk[1]), .dac_din_o(din[1]),
    .busy_o(busy[1]), .frame_done_o(done[1]), .dac_voltage_o(dacv[1]),
    .drop_cnt_o(drop[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: each frame is a time window ----------------
  int cyc;
  bit m_have[2];
  int m_t0[2];
  logic [11:0] m_code[2];
  bit m_pv[2];
  logic [11:0] m_pend[2];
  int m_drop[2];
  logic [11:0] m_last[2];
  logic e_sync[2], e_sclk[2], e_din[2], e_busy[2], e_done[2];

  function automatic int dv(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int gv(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic logic [15:0] sat16(input int x);
    logic [31:0] t;
    t = x;
    return (x > 65535) ? 16'hFFFF : t[15:0];
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 1'b0; m_pv[i] = 1'b0; m_drop[i] = 0; m_last[i] = '0;
      e_sync[i] = 1'b1; e_sclk[i] = 1'b1; e_din[i] = 1'b0;
      e_busy[i] = 1'b0; e_done[i] = 1'b0;
    end
  endtask

  task automatic model_start(input int i, input logic [11:0] c);
    m_have[i] = 1'b1;
    m_t0[i] = cyc;
    m_code[i] = c;
  endtask

  // called right after each rising edge with the inputs that edge sampled
  task automatic model_edge();
    int f, d, g, k;
    logic [15:0] word;
    if (!rst_n) return;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      d = dv(i); g = gv(i); f = 32 * d;
      if (m_have[i] && cyc < m_t0[i] + f + g) begin
        if (en) begin
          if (m_pv[i]) m_drop[i]++;
          m_pv[i] = 1'b1;
          m_pend[i] = v;
        end
      end else if (m_have[i]) begin
        if (en) begin
          if (m_pv[i]) m_drop[i]++;
          m_pv[i] = 1'b0;
          model_start(i, v);
        end else if (m_pv[i]) begin
          m_pv[i] = 1'b0;
          model_start(i, m_pend[i]);
        end else begin
          m_have[i] = 1'b0;
        end
      end else if (en) begin
        model_start(i, v);
      end
      k = cyc - m_t0[i];
      word = {2'b00, m_code[i], 2'b00};
      if (m_have[i] && k < f) begin
        e_sync[i] = 1'b0;
        e_sclk[i] = ((k % (2 * d)) < d);
        e_din[i]  = word[15 - k / (2 * d)];
      end else begin
        e_sync[i] = 1'b1; e_sclk[i] = 1'b1; e_din[i] = 1'b0;
      end
      e_done[i] = m_have[i] && (k == f);
      if (e_done[i]) m_last[i] = m_code[i];
      e_busy[i] = (m_have[i] && k < f + g) || m_pv[i];
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("sync_n[%0d]", i), 32'(sync_n[i]), 32'(e_sync[i]));
        check($sformatf("sclk[%0d]", i),   32'(sclk[i]),   32'(e_sclk[i]));
        check($sformatf("din[%0d]", i),    32'(din[i]),    32'(e_din[i]));
        check($sformatf("busy[%0d]", i),   32'(busy[i]),   32'(e_busy[i]));
        check($sformatf("done[%0d]", i),   32'(done[i]),   32'(e_done[i]));
        check($sformatf("dacv[%0d]", i),   32'(dacv[i]),   32'(m_last[i]));
        check($sformatf("drop[%0d]", i),   32'(drop[i]),   32'(sat16(m_drop[i])));
      end
    end
  end

  // ---------------- waveform measurements used by the literal checks ----------------
  int low_len[2], high_len[2], last_low[2], last_gap[2], nframes[2], ndone[2];
  logic [15:0] word_sh[2], last_word[2], prev_word[2];
  logic prev_sync[2], prev_sclk[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        low_len[i] = 0; high_len[i] = 0; prev_sync[i] = 1'b1; prev_sclk[i] = 1'b1;
      end else begin
        if (done[i]) ndone[i]++;
        if (!sync_n[i]) begin
          if (prev_sync[i]) begin
            last_gap[i] = high_len[i];
            low_len[i] = 0;
          end
          low_len[i]++;
          if (prev_sclk[i] && !sclk[i]) word_sh[i] = {word_sh[i][14:0], din[i]};
        end else begin
          if (!prev_sync[i]) begin
            last_low[i] = low_len[i];
            prev_word[i] = last_word[i];
            last_word[i] = word_sh[i];
            nframes[i]++;
            high_len[i] = 0;
          end
          high_len[i]++;
        end
        prev_sync[i] = sync_n[i];
        prev_sclk[i] = sclk[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic e, input logic [11:0] val);
    en = e;
    v = val;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 12'($urandom));
  endtask

  int n0, n1, dn0;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset sync_n", 32'(sync_n), 32'h3);
    check("reset sclk", 32'(sclk), 32'h3);
    check("reset din", 32'(din), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset dacv0", 32'(dacv[0]), 32'h0);
    check("reset drop0", 32'(drop[0]), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // single write
    n0 = nframes[0]; dn0 = ndone[0];
    tick(1'b1, 12'hA5C);
    idle(200);
    check("single frames0", 32'(nframes[0] - n0), 32'd1);
    check("single done0", 32'(ndone[0] - dn0), 32'd1);
    check("single word0", 32'(last_word[0]), 32'h2970);
    check("single low0", 32'(last_low[0]), 32'd128);
    check("single dacv0", 32'(dacv[0]), 32'hA5C);
    check("single drop0", 32'(drop[0]), 32'd0);
    check("single low1", 32'(last_low[1]), 32'd32);
    check("single word1", 32'(last_word[1]), 32'h2970);

    // coalescing
    n0 = nframes[0];
    tick(1'b1, 12'h100); idle(9);
    tick(1'b1, 12'h200); idle(9);
    tick(1'b1, 12'h300); idle(300);
    check("coal frames0", 32'(nframes[0] - n0), 32'd2);
    check("coal first0", 32'(prev_word[0]), 32'h0400);
    check("coal second0", 32'(last_word[0]), 32'h0C00);
    check("coal drop0", 32'(drop[0]), 32'd1);
    check("coal gap0", 32'(last_gap[0]), 32'd4);
    check("coal drop1", 32'(drop[1]), 32'd1);
    check("coal gap1", 32'(last_gap[1]), 32'd1);
    check("coal second1", 32'(last_word[1]), 32'h0C00);

    // strobe on the last GAP cycle while 0x111 is pending
    tick(1'b1, 12'h050);
    for (int t = 1; t <= 132; t++)
      tick((t == 20) || (t == 132), (t == 20) ? 12'h111 : 12'h222);
    idle(200);
    check("gapx first0", 32'(prev_word[0]), 32'h0140);
    check("gapx second0", 32'(last_word[0]), 32'h0888);
    check("gapx drop0", 32'(drop[0]), 32'd2);
    check("gapx dacv0", 32'(dacv[0]), 32'h222);
    check("gapx first1", 32'(prev_word[1]), 32'h0444);
    check("gapx drop1", 32'(drop[1]), 32'd1);

    // reset during bit 7 of a frame
    tick(1'b1, 12'h3C3);
    idle(58);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid-rst sync_n0", 32'(sync_n[0]), 32'd1);
    check("mid-rst sclk0", 32'(sclk[0]), 32'd1);
    check("mid-rst din0", 32'(din[0]), 32'd0);
    check("mid-rst busy0", 32'(busy[0]), 32'd0);
    n0 = nframes[0]; n1 = nframes[1]; dn0 = ndone[0];
    repeat (3) tick(1'b0, 12'h0);
    rst_n = 1'b1;
    idle(200);
    check("post-rst frames0", 32'(nframes[0] - n0), 32'd0);
    check("post-rst frames1", 32'(nframes[1] - n1), 32'd0);
    check("post-rst done0", 32'(ndone[0] - dn0), 32'd0);
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst dacv0", 32'(dacv[0]), 32'd0);

    // randomized traffic, dense then sparse
    repeat (3000) tick($urandom_range(0, 3) == 0, 12'($urandom));
    repeat (2000) tick($urandom_range(0, 49) == 0, 12'($urandom));
    idle(300);

    // continuous updates: back-to-back frames and drop counter saturation
    repeat (68500) tick(1'b1, 12'($urandom));
    check("sat drop0", 32'(drop[0]), 32'hFFFF);
    check("sat drop1", 32'(drop[1]), 32'hFFFF);
    check("cont low1", 32'(last_low[1]), 32'd32);
    check("cont gap1", 32'(last_gap[1]), 32'd1);
    check("cont low0", 32'(last_low[0]), 32'd128);
    check("cont gap0", 32'(last_gap[0]), 32'd4);
    idle(200);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/laser_aom_dac_drv.md
# laser_aom_dac_drv

Consumes the AOM voltage update stream (`laser_aom_en` strobe plus 12-bit `laser_aom_voltage` code) produced by the laser AOM controller and serialises each update into a 16-bit SPI write frame for the external 12-bit AOM DAC (DAC7311-style: SYNC_N-framed, MSB first, sampled on SCLK falling edge). It sits between the AOM controller and the board DAC pins. Updates arriving while a frame is in flight are coalesced so that only the newest value is written, and every discarded value is counted.

## Interface
- `CLK_DIV`, 4: SCLK half-period in `clk_i` cycles; SCLK = clk_i / (2·CLK_DIV); legal ≥1.
- `SYNC_GAP`, 4: minimum SYNC_N high time between frames, in `clk_i` cycles; legal ≥1.
- `TCQ`, 0.1: simulation clock-to-Q delay.
- `clk_i` input 1: system clock; all logic in this single domain.
- `rst_n_i` input 1: reset, asynchronous assert, active-low.
- `aom_en_i` input 1: one-cycle update strobe; `aom_voltage_i` is valid in the same cycle.
- `aom_voltage_i` input 12: DAC code to write.
- `dac_sync_n_o` output 1: DAC frame select, active-low.
- `dac_sclk_o` output 1: DAC serial clock, idles high.
- `dac_din_o` output 1: DAC serial data, MSB first.
- `busy_o` output 1: high when not IDLE or an update is pending.
- `frame_done_o` output 1: one-cycle pulse when a frame completes.
- `dac_voltage_o` output 12: code of the last completed frame.
- `drop_cnt_o` output 16: saturating count of overwritten/superseded updates.

## Operation
- Frame word: {2'b00 (normal mode), code[11:0], 2'b00}; shifted MSB first, 16 bits.
- States: IDLE, SHIFT, GAP.
- IDLE: `aom_en_i`=1 → load shift register from `aom_voltage_i`, go SHIFT.
- SHIFT: SYNC_N low; each bit occupies 2·CLK_DIV cycles: SCLK high for CLK_DIV cycles with DIN = current MSB, then SCLK low for CLK_DIV cycles (DAC samples on falling edge), then SCLK rises and the register shifts left. After the 16th low phase → SYNC_N high, SCLK high, DIN 0, `frame_done_o`=1, `dac_voltage_o` ← frame code, go GAP.
- GAP: hold SYNC_GAP cycles. On the last GAP cycle: if `aom_en_i` → start new frame from `aom_voltage_i` (if pending was also valid, drop it, drop_cnt+1); else if pending valid → start frame from pending, clear pending; else → IDLE.
- Pending register: `aom_en_i` during SHIFT or GAP (except the GAP-exit cycle above) writes pending; if pending already valid, overwrite and drop_cnt+1.
- `drop_cnt_o` saturates at 16'hFFFF; never wraps.
- `busy_o` = (state≠IDLE) | pending_valid.

## Timing
- Reset values: `dac_sync_n_o`=1, `dac_sclk_o`=1, `dac_din_o`=0, `busy_o`=0, `frame_done_o`=0, `dac_voltage_o`=0, `drop_cnt_o`=0; pending cleared, state IDLE. All outputs registered.
- Latency: strobe sampled at edge N in IDLE → SYNC_N low and DIN = bit15 from edge N+1.
- First SCLK falling edge at N+1+CLK_DIV; SYNC_N low for exactly 32·CLK_DIV cycles.
- `frame_done_o` and `dac_voltage_o` update on the same edge as SYNC_N rise.
- Back-to-back: next SYNC_N fall exactly SYNC_GAP cycles after previous SYNC_N rise when an update is waiting; frame period = 32·CLK_DIV + SYNC_GAP.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous), partial frame abandoned, pending discarded, no `frame_done_o`.
- `aom_voltage_i` is sampled only in strobe cycles; value changes without strobe are ignored.

## Test plan
- Single write, CLK_DIV=4, SYNC_GAP=4: strobe code 12'hA5C → SYNC_N low 128 cycles, DIN sequence 0,0,1010 0101 1100,0,0 sampled at SCLK falls, `frame_done_o` one pulse, `dac_voltage_o`=12'hA5C, `drop_cnt_o`=0.
- Coalescing: strobes 12'h100, 12'h200, 12'h300 at 10-cycle spacing → two frames (0x100 then 0x300), `drop_cnt_o`=1, second SYNC_N fall 4 cycles after first rise.
- GAP-exit collision: pending 12'h111 valid, strobe 12'h222 on last GAP cycle → next frame carries 0x222, `drop_cnt_o` increments by 1.
- Reset mid-frame: assert `rst_n_i` low at bit 7 → SYNC_N=1, SCLK=1, DIN=0 same cycle; after release with no strobe, `busy_o`=0 and no frame.
- Saturation: preload via 65540 superseded strobes (or forced counter 16'hFFFE, three drops) → `drop_cnt_o` stays 16'hFFFF.
- CLK_DIV=1, SYNC_GAP=1: strobe 12'hFFF → SYNC_N low 32 cycles, SCLK toggles every cycle, frame period 33 cycles under continuous updates.
